// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI write master: 16-bit {W, addr, data} frames, mode 0.
// Every output is a flop loaded from the previous cycle's state, so pins lag the FSM by one clock.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       ncs,
    output logic       sclk,
    output logic       copi,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic        phase_q, phase_d;
    logic [15:0] shift_q, shift_d;
    logic        ncs_q, ncs_d;
    logic        sclk_q, sclk_d;
    logic        copi_q, copi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div_last;
    logic        frame_active;

    assign div_last     = (div_q == DIV_LAST);
    assign frame_active = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

    always_comb begin
        state_d = state_q;
        div_d   = div_last ? 8'd0 : div_q + 8'd1;
        bit_d   = bit_q;
        phase_d = phase_q;
        shift_d = shift_q;
        busy_d  = (state_q != IDLE);
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                div_d = 8'd0;
                if (start) begin
                    state_d = SETUP;
                    shift_d = {1'b1, addr, wdata};
                    bit_d   = 4'd0;
                    phase_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // phase_q=1 is the sclk-high half; data advances when it ends
                if (div_last) begin
                    if (phase_q) begin
                        phase_d = 1'b0;
                        if (bit_q != 4'd15) begin
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                    end else if (bit_q == 4'd15) begin
                        state_d = HOLD;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        phase_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (div_last) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (div_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ncs_d  = !frame_active;
        sclk_d = (state_q == SHIFT) && phase_q;
        copi_d = frame_active && shift_q[15];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= 4'd0;
            phase_q <= 1'b0;
            shift_q <= 16'd0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ncs  = ncs_q;
    assign sclk = sclk_q;
    assign copi = copi_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - bench for spi_controller with a cycle-timing model and a wire-level peripheral.
module tb_spi_controller;
    localparam int D  = 4;
    localparam int D2 = 255;

    typedef struct packed {
        logic ncs;
        logic sclk;
        logic copi;
        logic busy;
        logic done;
    } out_t;

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] exp_frame;
    } vec_t;

    typedef struct {
        int          cnt;
        logic [15:0] bits;
    } rx_t;

    localparam out_t IDLE_O = 5'b10000;

    logic       clk = 1'b0;
    logic       rst, start, start2;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       ncs, sclk, copi, busy, done;
    logic       ncs2, sclk2, copi2, busy2, done2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(D)) u_dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .wdata(wdata),
        .ncs(ncs), .sclk(sclk), .copi(copi), .busy(busy), .done(done)
    );

    spi_controller #(.CLK_DIV(D2)) u_dut255 (
        .clk(clk), .rst(rst), .start(start2), .addr(7'h15), .wdata(8'h3C),
        .ncs(ncs2), .sclk(sclk2), .copi(copi2), .busy(busy2), .done(done2)
    );

    // Expected pins n cycles after the accepting edge of frame f.
    function automatic out_t ref_out(int n, logic [15:0] f, int dv);
        out_t o;
        int   m, b, w;
        o = IDLE_O;
        if (n >= 0 && n <= 35 * dv) o.busy = 1'b1;
        if (n == 35 * dv) o.done = 1'b1;
        if (n >= 1 && n <= 34 * dv) begin
            o.ncs = 1'b0;
            if (n <= dv) begin
                o.copi = f[15];
            end else if (n <= 33 * dv) begin
                m = n - dv - 1;
                b = m / (2 * dv);
                w = m % (2 * dv);
                o.sclk = (w < dv);
                if (w < dv)      o.copi = f[15 - b];
                else if (b < 15) o.copi = f[14 - b];
                else             o.copi = f[0];
            end else begin
                o.copi = f[0];
            end
        end
        return o;
    endfunction

    // Transaction-level model: one frame at a time, starts ignored while one is in flight.
    int          edge_n = 0;
    bit          m_active = 0;
    int          m_t0 = 0;
    logic [15:0] m_frame = 16'd0;
    out_t        exp_o = IDLE_O;
    bit          model_valid = 0;

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (m_active && (edge_n - m_t0) > 35 * D) m_active = 0;
            if (rst) begin
                m_active = 0;
            end else if (!m_active && start) begin
                m_active = 1;
                m_t0     = edge_n;
                m_frame  = {1'b1, addr, wdata};
            end
            exp_o       = m_active ? ref_out(edge_n - m_t0, m_frame, D) : IDLE_O;
            model_valid = 1;
        end
    end

    // Per-cycle pin check plus a peripheral that shifts copi on sclk rises.
    logic        p_ncs = 1'b1;
    logic        p_sclk = 1'b0;
    logic [15:0] p_bits = 16'd0;
    int          p_cnt = 0;
    int          done_cnt = 0;
    logic [7:0]  p_regs [128];
    rx_t         rx_q [$];

    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                total++;
                if ({ncs, sclk, copi, busy, done} !== exp_o) begin
                    bad++;
                    $display("FAIL pins edge=%0d ncs,sclk,copi,busy,done got=%b required=%b",
                             edge_n, {ncs, sclk, copi, busy, done}, exp_o);
                end
            end
            if (done === 1'b1) done_cnt++;
            if (!ncs && sclk && !p_sclk) begin
                p_bits = {p_bits[14:0], copi};
                p_cnt++;
            end
            if (ncs && !p_ncs) begin
                rx_q.push_back('{p_cnt, p_bits});
                if (p_cnt == 16 && p_bits[15]) p_regs[p_bits[14:8]] = p_bits[7:0];
                p_cnt  = 0;
                p_bits = 16'd0;
            end
            p_sclk = sclk;
            p_ncs  = ncs;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic check_rx(string name, int exp_cnt, logic [15:0] exp_bits);
        rx_t r;
        if (rx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s got=no_frame required=%0h", name, exp_bits);
        end else begin
            r = rx_q.pop_front();
            check({name, "_edges"}, 32'(r.cnt), 32'(exp_cnt));
            check({name, "_bits"}, 32'(r.bits), 32'(exp_bits));
        end
    endtask

    // Called at a negedge; returns at the first cycle the next start can be accepted.
    task automatic send(logic [6:0] a, logic [7:0] d);
        start = 1'b1;
        addr  = a;
        wdata = d;
        tick(1);
        start = 1'b0;
        addr  = 7'($urandom);
        wdata = 8'($urandom);
        tick(35 * D + 1);
    endtask

    vec_t       vecs [6];
    logic [7:0] loop_data [5];
    logic [6:0] ra;
    logic [7:0] rd;
    int         dc0;
    int         rises, runbad, done_at, hi, lo;
    logic       prev;

    initial begin
        vecs[0] = '{7'h00, 8'hA5, 16'h80A5};
        vecs[1] = '{7'h04, 8'h80, 16'h8480};
        vecs[2] = '{7'h7F, 8'hFF, 16'hFFFF};
        vecs[3] = '{7'h2A, 8'h00, 16'hAA00};
        vecs[4] = '{7'h01, 8'h22, 16'h8122};
        vecs[5] = '{7'h55, 8'h0F, 16'hD50F};
        loop_data[0] = 8'h11; loop_data[1] = 8'h22; loop_data[2] = 8'h33;
        loop_data[3] = 8'h44; loop_data[4] = 8'h80;

        rst = 1'b1; start = 1'b0; start2 = 1'b0; addr = 7'd0; wdata = 8'd0;
        tick(3);
        check("reset_pins", 32'({ncs, sclk, copi, busy, done}), 32'(IDLE_O));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].addr, vecs[i].wdata);
            check_rx($sformatf("vec%0d", i), 16, vecs[i].exp_frame);
        end

        for (int i = 0; i < 6; i++) begin
            ra = 7'($urandom);
            rd = 8'($urandom);
            send(ra, rd);
            check_rx($sformatf("rand%0d", i), 16, {1'b1, ra, rd});
        end

        // start held high: second frame accepted at cycle 35*D+1
        start = 1'b1; addr = 7'h04; wdata = 8'h80;
        tick(35 * D + 2);
        check("b2b_busy_at_accept", 32'(busy), 32'd1);
        check("b2b_ncs_at_accept", 32'(ncs), 32'd1);
        start = 1'b0;
        tick(1);
        check("b2b_ncs_low_next", 32'(ncs), 32'd0);
        tick(35 * D);
        check_rx("b2b_first", 16, 16'h8480);
        check_rx("b2b_second", 16, 16'h8480);

        // start pulsed mid-frame with other data
        dc0 = done_cnt;
        start = 1'b1; addr = 7'h10; wdata = 8'h5A;
        tick(1);
        start = 1'b0;
        tick(49);
        start = 1'b1; addr = 7'h33; wdata = 8'hCC;
        tick(1);
        start = 1'b0;
        tick(35 * D + 1 - 51);
        check_rx("midstart", 16, 16'h905A);
        check("midstart_done_pulses", 32'(done_cnt - dc0), 32'd1);

        // reset after the 7th sclk rise
        dc0 = done_cnt;
        start = 1'b1; addr = 7'h55; wdata = 8'h0F;
        tick(1);
        start = 1'b0;
        tick(55);
        rst = 1'b1;
        tick(1);
        check("abort_pins", 32'({ncs, sclk, copi, busy, done}), 32'(IDLE_O));
        rst = 1'b0;
        tick(10);
        check_rx("abort_partial", 7, 16'h006A);
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        send(7'h55, 8'h0F);
        check_rx("after_abort", 16, 16'hD50F);

        // start held through reset is taken on the first cycle after release
        rst = 1'b1; start = 1'b1; addr = 7'h0A; wdata = 8'h3C;
        tick(2);
        check("start_in_reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(1);
        check("start_after_reset_busy", 32'(busy), 32'd1);
        start = 1'b0;
        tick(35 * D + 1);
        check_rx("start_after_reset", 16, 16'h8A3C);

        for (int i = 0; i < 5; i++) begin
            send(7'(i), loop_data[i]);
            check_rx($sformatf("loop%0d", i), 16, {1'b1, 7'(i), loop_data[i]});
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("periph_reg%0d", i), 32'(p_regs[i]), 32'(loop_data[i]));
        end

        // slowest divider: phase lengths and done cycle
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        rises = 0; runbad = 0; done_at = -1; hi = 0; lo = 0; prev = 1'b0;
        for (int n = 1; n <= 35 * D2 + 1; n++) begin
            tick(1);
            if (sclk2) begin
                if (!prev) begin
                    rises++;
                    if (ncs2 || (rises > 1 && lo != D2)) runbad++;
                end
                hi = prev ? hi + 1 : 1;
            end else begin
                if (prev && hi != D2) runbad++;
                lo = prev ? 1 : lo + 1;
            end
            if (done2) done_at = n;
            prev = sclk2;
        end
        check("div255_rises", 32'(rises), 32'd16);
        check("div255_bad_phases", 32'(runbad), 32'd0);
        check("div255_done_cycle", 32'(done_at), 32'(35 * D2));
        check("div255_busy_end", 32'(busy2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning the SCLK half-period in clk cycles; legal range 4..255.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, and reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request a write transaction; sampled only in IDLE.
REQ-005 SHALL have port addr, input, 7, register address; captured when start is accepted.
REQ-006 SHALL have port wdata, input, 8, write data; captured when start is accepted.
REQ-007 SHALL have port ncs, output, 1, active-low chip select to the peripheral.
REQ-008 SHALL have port sclk, output, 1, serial clock; mode 0, idle low.
REQ-009 SHALL have port copi, output, 1, serial data to the peripheral.
REQ-010 SHALL have port busy, output, 1, high from the accepted-start cycle until return to IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at transaction completion.

Function
REQ-012 SHALL implement states IDLE, SETUP, SHIFT, HOLD and GAP, with an 8-bit divider counter and a 4-bit bit counter.
REQ-013 SHALL form a 16-bit frame {1'b1 (write), addr[6:0], wdata[7:0]}, shifted MSB first; bit 15 is the R/W bit.
REQ-014 SHALL accept start only when the state is IDLE.
- In the acceptance cycle (cycle 0): capture the frame, set busy=1, go to SETUP.
- start asserted while busy SHALL be ignored; no queueing.
REQ-015 SHALL drive SETUP from cycle 1 for CLK_DIV cycles: ncs=0, sclk=0, copi=frame bit 15.
REQ-016 SHALL perform 16 bit periods in SHIFT, each consisting of sclk=1 for CLK_DIV cycles followed by sclk=0 for CLK_DIV cycles.
- copi SHALL change only in the cycle sclk falls, to the next bit.
- copi SHALL be stable for the entire sclk-high phase.
REQ-017 SHALL hold bit 0 on copi after the 16th falling edge, then enter HOLD for CLK_DIV cycles with ncs=0 and sclk=0.
REQ-018 SHALL then enter GAP for CLK_DIV cycles with ncs=1, sclk=0, copi=0.
- done=1 in the last GAP cycle only.
- Next cycle: IDLE and busy=0.
REQ-019 SHALL produce this timing: ncs low for exactly 34*CLK_DIV cycles (cycles 1..34*CLK_DIV); done at cycle 35*CLK_DIV; busy low from cycle 35*CLK_DIV+1.
REQ-020 SHALL accept the earliest next start at cycle 35*CLK_DIV+1.
- Minimum ncs-high time between frames: CLK_DIV+1 cycles.
REQ-021 SHALL produce exactly 16 rising edges of sclk per frame and none while ncs=1.
REQ-022 SHALL drive all outputs from registers (no combinational paths from inputs to outputs).
REQ-023 SHALL ignore changes to addr/wdata after acceptance; the transmitted frame uses only the captured values.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, force state=IDLE, ncs=1, sclk=0, copi=0, busy=0, done=0, and clear the counters and shift register.
REQ-025 SHALL, on reset during any non-IDLE state, abort the frame.
- ncs=1 and sclk=0 from the next edge.
- No done pulse.
- No partial frame resumes after reset release.
REQ-026 SHALL ignore start while rst=1; the first acceptable start is in the cycle after rst deasserts.

Verification
REQ-027 SHALL be covered by: CLK_DIV=4, start with addr=0x00, wdata=0xA5 -> copi sampled at the 16 sclk rising edges = 1,0000000,10100101; ncs low cycles 1..136; done at cycle 140; busy=0 at cycle 141.
REQ-028 SHALL be covered by: back-to-back start held high continuously with addr=0x04, wdata=0x80 -> second frame accepted at cycle 141, ncs high for cycles 137..141, both frames identical on the wire.
REQ-029 SHALL be covered by: start pulsed at cycle 50 of an active frame with different addr/wdata -> ignored, frame unchanged, single done pulse.
REQ-030 SHALL be covered by: rst asserted during SHIFT after 7 sclk rising edges -> next cycle ncs=1, sclk=0, copi=0, busy=0, no done; a later start sends a full 16-bit frame.
REQ-031 SHALL be covered by: closed loop with the existing SPI peripheral on the same clk, writing addresses 0..4 with data 0x11, 0x22, 0x33, 0x44, 0x80 -> peripheral registers en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle take those values.
REQ-032 SHALL be covered by: CLK_DIV=255 single frame -> sclk high and low phases each exactly 255 cycles; done at cycle 8925.
